// File: rtl/instr_pkg.sv
// Shared types and field layout for the instruction ROM loader.
// The A/C word layout is fixed for 16-bit instruction words.
package instr_pkg;

    typedef enum logic {
        A_INSTR = 1'b0,
        C_INSTR = 1'b1
    } instr_type_e;

    localparam int COMP_W   = 6;
    localparam int DEST_W   = 3;
    localparam int JUMP_W   = 3;

    localparam int A_BIT    = 12;
    localparam int COMP_LSB = 6;
    localparam int DEST_LSB = 3;
    localparam int JUMP_LSB = 0;

    localparam logic [2:0] C_PREFIX = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } enc_state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: decoded A/C instruction fields -> one instruction word.
// Fields not belonging to the selected instruction type are ignored.
module instr_field_pack
    import instr_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                i_type,
    input  logic [DW-2:0]       i_value,
    input  logic                i_a,
    input  logic [COMP_W-1:0]   i_comp,
    input  logic [DEST_W-1:0]   i_dest,
    input  logic [JUMP_W-1:0]   i_jump,
    output logic [DW-1:0]       o_word
);

    always_comb begin
        o_word = '0;
        if (i_type == logic'(C_INSTR)) begin
            o_word[DW-1 -: 3]            = C_PREFIX;
            o_word[A_BIT]                = i_a;
            o_word[COMP_LSB +: COMP_W]   = i_comp;
            o_word[DEST_LSB +: DEST_W]   = i_dest;
            o_word[JUMP_LSB +: JUMP_W]   = i_jump;
        end else begin
            o_word = {1'b0, i_value};
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction ROM loader: packs streamed A/C fields into words written from address 0.
// Optional XOR checksum of all written words is enabled by defining INSTR_ENC_CHECKSUM_EN.
module instr_encoder
    import instr_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_type,
    input  logic [DW-2:0]       in_value,
    input  logic                in_a,
    input  logic [COMP_W-1:0]   in_comp,
    input  logic [DEST_W-1:0]   in_dest,
    input  logic [JUMP_W-1:0]   in_jump,
    input  logic                in_last,
    output logic                rom_we,
    output logic [AW-1:0]       rom_addr,
    output logic [DW-1:0]       rom_wdata,
    output logic                busy,
    output logic                done,
    output logic                err_overflow,
    output logic [AW:0]         word_count,
    output logic [DW-1:0]       checksum
);

    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    enc_state_e     r_state;
    enc_state_e     w_next;
    logic [AW-1:0]  r_addr;
    logic [AW:0]    r_word_count;
    logic           r_rom_we;
    logic [AW-1:0]  r_rom_addr;
    logic [DW-1:0]  r_rom_wdata;
    logic           r_done;
    logic           w_hs;
    logic           w_start_ok;
    logic [DW-1:0]  w_word;

    instr_field_pack #(.DW(DW)) u_pack (
        .i_type  (in_type),
        .i_value (in_value),
        .i_a     (in_a),
        .i_comp  (in_comp),
        .i_dest  (in_dest),
        .i_jump  (in_jump),
        .o_word  (w_word)
    );

    assign in_ready     = (r_state == LOAD);
    assign busy         = (r_state == LOAD);
    assign err_overflow = (r_state == ERR);
    assign w_hs         = in_valid && in_ready;
    // start is honoured only from IDLE or ERR; LOAD and the DONE cycle ignore it
    assign w_start_ok   = start && ((r_state == IDLE) || (r_state == ERR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = LOAD;
            LOAD: begin
                if (w_hs) begin
                    if (in_last)                  w_next = DONE;
                    else if (r_addr == LAST_ADDR) w_next = ERR;
                end
            end
            DONE: w_next = IDLE;
            ERR:  if (start) w_next = LOAD;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_word_count <= '0;
            r_rom_we     <= 1'b0;
            r_rom_addr   <= '0;
            r_rom_wdata  <= '0;
            r_done       <= 1'b0;
        end else begin
            r_rom_we <= w_hs;
            r_done   <= (r_state == DONE);
            if (w_hs) begin
                r_rom_addr  <= r_addr;
                r_rom_wdata <= w_word;
            end
            if (w_start_ok) begin
                r_addr <= '0;
            end else if (w_hs) begin
                r_addr <= r_addr + 1'b1;
            end
            // count follows the write strobe so it matches words actually in the ROM
            if (w_start_ok) begin
                r_word_count <= '0;
            end else if (r_rom_we) begin
                r_word_count <= r_word_count + 1'b1;
            end
        end
    end

    assign rom_we     = r_rom_we;
    assign rom_addr   = r_rom_addr;
    assign rom_wdata  = r_rom_wdata;
    assign done       = r_done;
    assign word_count = r_word_count;

`ifdef INSTR_ENC_CHECKSUM_EN
    logic [DW-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_rom_we) begin
            r_checksum <= r_checksum ^ r_rom_wdata;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default-size instance plus an AW=2 instance for overflow.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 0, in_valid = 0, in_type = 0, in_a = 0, in_last = 0;
    logic [14:0] in_value = '0;
    logic [5:0]  in_comp = '0;
    logic [2:0]  in_dest = '0, in_jump = '0;

    logic        m_in_ready, m_rom_we, m_busy, m_done, m_err;
    logic [7:0]  m_rom_addr;
    logic [15:0] m_rom_wdata, m_checksum;
    logic [8:0]  m_word_count;

    logic        s_in_ready, s_rom_we, s_busy, s_done, s_err;
    logic [1:0]  s_rom_addr;
    logic [15:0] s_rom_wdata, s_checksum;
    logic [2:0]  s_word_count;

    instr_encoder #(.DW(16), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_type(in_type), .in_value(in_value), .in_a(in_a), .in_comp(in_comp),
        .in_dest(in_dest), .in_jump(in_jump), .in_last(in_last), .rom_we(m_rom_we),
        .rom_addr(m_rom_addr), .rom_wdata(m_rom_wdata), .busy(m_busy), .done(m_done),
        .err_overflow(m_err), .word_count(m_word_count), .checksum(m_checksum)
    );

    instr_encoder #(.DW(16), .AW(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_type(in_type), .in_value(in_value), .in_a(in_a), .in_comp(in_comp),
        .in_dest(in_dest), .in_jump(in_jump), .in_last(in_last), .rom_we(s_rom_we),
        .rom_addr(s_rom_addr), .rom_wdata(s_rom_wdata), .busy(s_busy), .done(s_done),
        .err_overflow(s_err), .word_count(s_word_count), .checksum(s_checksum)
    );

    // ROM write logs: {addr, data} per observed write strobe
    logic [23:0] cap_m[$];
    logic [17:0] cap_s[$];
    logic [15:0] exp_q[$];
    int total = 0;
    int bad = 0;
    bit sel = 0;

    always @(negedge clk) begin
        if (m_rom_we === 1'b1) cap_m.push_back({m_rom_addr, m_rom_wdata});
        if (s_rom_we === 1'b1) cap_s.push_back({s_rom_addr, s_rom_wdata});
    end

    function automatic logic [15:0] ref_word(bit t, logic [14:0] v, logic a,
                                             logic [5:0] c, logic [2:0] d, logic [2:0] j);
        int w;
        if (!t) begin
            w = int'(v);
        end else begin
            w = 'hE000 + int'(a) * 4096 + int'(c) * 64 + int'(d) * 8 + int'(j);
        end
        return w[15:0];
    endfunction

    function automatic logic [15:0] ref_checksum();
        logic [15:0] x = '0;
`ifdef INSTR_ENC_CHECKSUM_EN
        foreach (exp_q[i]) x ^= exp_q[i];
`endif
        return x;
    endfunction

    // Present one word; returns at the falling edge after its handshake (or after the wait budget).
    task automatic drive(input bit t, input logic [14:0] v, input logic a, input logic [5:0] c,
                         input logic [2:0] d, input logic [2:0] j, input bit last,
                         input int gap, output bit acc);
        in_valid = 0;
        repeat (gap) @(negedge clk);
        in_type = t; in_value = v; in_a = a; in_comp = c; in_dest = d; in_jump = j;
        in_last = last; in_valid = 1;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            if ((sel ? s_in_ready : m_in_ready) === 1'b1) begin
                acc = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 0;
        exp_q.push_back(ref_word(t, v, a, c, d, j));
    endtask

    task automatic drive_rand(input bit last, input int gap, output bit acc);
        drive(1'($urandom), 15'($urandom), 1'($urandom), 6'($urandom), 3'($urandom),
              3'($urandom), last, gap, acc);
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        cap_m.delete();
        cap_s.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(output bit seen);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (m_done === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({m_in_ready, m_rom_we, m_rom_addr, m_rom_wdata, m_busy, m_done, m_err,
             m_word_count, m_checksum} !== '0) begin
            bad++;
            $display("FAIL reset_main: got ready=%b we=%b addr=%h data=%h busy=%b done=%b err=%b cnt=%0d ck=%h want all 0",
                     m_in_ready, m_rom_we, m_rom_addr, m_rom_wdata, m_busy, m_done, m_err, m_word_count, m_checksum);
        end
        total++;
        if ({s_in_ready, s_rom_we, s_rom_addr, s_rom_wdata, s_busy, s_done, s_err,
             s_word_count, s_checksum} !== '0) begin
            bad++;
            $display("FAIL reset_small: outputs not all 0 (ready=%b busy=%b err=%b)", s_in_ready, s_busy, s_err);
        end
        rst_n = 1;
        @(negedge clk);
        total++;
        if (m_in_ready !== 1'b0 || m_busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_ready: got ready=%b busy=%b want 0 0", m_in_ready, m_busy);
        end
    endtask

    task automatic test_single_a();
        bit acc;
        start_session();
        drive(0, 15'h0015, 0, 6'h0, 3'h0, 3'h0, 1, 0, acc);
        total++;
        if (m_rom_we !== 1'b1 || m_rom_addr !== 8'd0 || m_rom_wdata !== 16'h0015 || m_done !== 1'b0) begin
            bad++;
            $display("FAIL single_write: got we=%b addr=%h data=%h done=%b want 1 00 0015 0",
                     m_rom_we, m_rom_addr, m_rom_wdata, m_done);
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b1 || m_word_count !== 9'd1 || m_rom_we !== 1'b0) begin
            bad++;
            $display("FAIL single_done: got done=%b cnt=%0d we=%b want 1 1 0", m_done, m_word_count, m_rom_we);
        end
        @(negedge clk);
        total++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_word_count !== 9'd1) begin
            bad++;
            $display("FAIL single_after: got done=%b busy=%b cnt=%0d want 0 0 1", m_done, m_busy, m_word_count);
        end
    endtask

    task automatic test_c_words();
        bit acc, seen;
        logic [15:0] ck;
        start_session();
        drive(1, 15'h7fff, 0, 6'b110000, 3'b010, 3'b000, 0, 0, acc);
        drive(1, 15'h1234, 0, 6'b001100, 3'b000, 3'b001, 1, 0, acc);
        wait_done(seen);
        repeat (2) @(negedge clk);
        total++;
        if (cap_m.size() != 2) begin
            bad++;
            $display("FAIL cword_count: got %0d writes want 2", cap_m.size());
        end else begin
            total++;
            if (cap_m[0] !== {8'd0, 16'hEC10} || cap_m[1] !== {8'd1, 16'hE301}) begin
                bad++;
                $display("FAIL cword_data: got %h %h want 00ec10 01e301", cap_m[0], cap_m[1]);
            end
        end
        // three-word program whose XOR is a known constant
        start_session();
        drive(0, 15'h0015, 1, 6'h3f, 3'h7, 3'h7, 0, 0, acc);
        drive(1, 15'h0, 0, 6'b110000, 3'b010, 3'b000, 0, 0, acc);
        drive(1, 15'h0, 0, 6'b001100, 3'b000, 3'b001, 1, 0, acc);
        wait_done(seen);
`ifdef INSTR_ENC_CHECKSUM_EN
        ck = 16'h0F04;
`else
        ck = 16'h0000;
`endif
        total++;
        if (!seen || m_checksum !== ck || m_word_count !== 9'd3) begin
            bad++;
            $display("FAIL checksum: got done=%b ck=%h cnt=%0d want 1 %h 3", seen, m_checksum, m_word_count, ck);
        end
    endtask

    task automatic test_backpressure();
        bit acc, seen;
        start_session();
        for (int i = 0; i < 5; i++) drive_rand(i == 4, 1, acc);
        wait_done(seen);
        total++;
        if (!seen || m_word_count !== 9'd5) begin
            bad++;
            $display("FAIL bp_done: got done=%b cnt=%0d want 1 5", seen, m_word_count);
        end
        repeat (2) @(negedge clk);
        total++;
        if (cap_m.size() != 5) begin
            bad++;
            $display("FAIL bp_writes: got %0d writes want 5", cap_m.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (cap_m[i] !== {8'(i), exp_q[i]}) begin
                    bad++;
                    $display("FAIL bp_word%0d: got %h want %h", i, cap_m[i], {8'(i), exp_q[i]});
                end
            end
        end
    endtask

    task automatic test_random();
        bit acc, seen;
        int len;
        for (int s = 0; s < 4; s++) begin
            start_session();
            len = $urandom_range(3, 14);
            for (int i = 0; i < len; i++) begin
                if (i == 2) begin
                    // a start pulse mid-session must not restart the address sequence
                    @(negedge clk);
                    start = 1;
                    @(negedge clk);
                    start = 0;
                end
                drive_rand(i == len - 1, $urandom_range(0, 2), acc);
            end
            wait_done(seen);
            total++;
            if (!seen || m_word_count !== 9'(len) || m_checksum !== ref_checksum()) begin
                bad++;
                $display("FAIL rand%0d_done: got done=%b cnt=%0d ck=%h want 1 %0d %h",
                         s, seen, m_word_count, m_checksum, len, ref_checksum());
            end
            repeat (2) @(negedge clk);
            total++;
            if (cap_m.size() != len) begin
                bad++;
                $display("FAIL rand%0d_writes: got %0d want %0d", s, cap_m.size(), len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    total++;
                    if (cap_m[i] !== {8'(i), exp_q[i]}) begin
                        bad++;
                        $display("FAIL rand%0d_word%0d: got %h want %h", s, i, cap_m[i], {8'(i), exp_q[i]});
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit acc, seen;
        start_session();
        drive(0, 15'h0101, 0, 6'h0, 3'h0, 3'h0, 0, 0, acc);
        in_type = 0; in_value = 15'h0202; in_last = 0; in_valid = 1;
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        total++;
        if ({m_in_ready, m_rom_we, m_rom_addr, m_rom_wdata, m_busy, m_done, m_err,
             m_word_count, m_checksum} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs: got we=%b addr=%h data=%h busy=%b cnt=%0d want all 0",
                     m_rom_we, m_rom_addr, m_rom_wdata, m_busy, m_word_count);
        end
        @(negedge clk);
        in_valid = 0;
        rst_n = 1;
        total++;
        if (cap_m.size() != 1 || cap_m[0] !== {8'd0, 16'h0101}) begin
            bad++;
            $display("FAIL midreset_log: got %0d writes first=%h want 1 000101", cap_m.size(), cap_m[0]);
        end
        start_session();
        drive(0, 15'h0303, 0, 6'h0, 3'h0, 3'h0, 1, 0, acc);
        total++;
        if (m_rom_we !== 1'b1 || m_rom_addr !== 8'd0 || m_rom_wdata !== 16'h0303) begin
            bad++;
            $display("FAIL midreset_restart: got we=%b addr=%h data=%h want 1 00 0303", m_rom_we, m_rom_addr, m_rom_wdata);
        end
        wait_done(seen);
        total++;
        if (!seen || m_word_count !== 9'd1) begin
            bad++;
            $display("FAIL midreset_done: got done=%b cnt=%0d want 1 1", seen, m_word_count);
        end
    endtask

    task automatic test_overflow();
        bit acc;
        @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        sel = 1;
        start_session();
        for (int i = 0; i < 4; i++) begin
            drive_rand(0, 0, acc);
            total++;
            if (!acc) begin
                bad++;
                $display("FAIL ovf_accept%0d: got not accepted want accepted", i);
            end
        end
        drive_rand(0, 0, acc);
        total++;
        if (acc || s_err !== 1'b1 || s_in_ready !== 1'b0 || s_busy !== 1'b0) begin
            bad++;
            $display("FAIL ovf_state: got acc=%b err=%b ready=%b busy=%b want 0 1 0 0", acc, s_err, s_in_ready, s_busy);
        end
        total++;
        if (cap_s.size() != 4 || s_word_count !== 3'd4) begin
            bad++;
            $display("FAIL ovf_count: got writes=%0d cnt=%0d want 4 4", cap_s.size(), s_word_count);
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (cap_s[i] !== {2'(i), exp_q[i]}) begin
                    bad++;
                    $display("FAIL ovf_word%0d: got %h want %h", i, cap_s[i], {2'(i), exp_q[i]});
                end
            end
        end
        start_session();
        total++;
        if (s_err !== 1'b0 || s_busy !== 1'b1 || s_word_count !== 3'd0) begin
            bad++;
            $display("FAIL ovf_clear: got err=%b busy=%b cnt=%0d want 0 1 0", s_err, s_busy, s_word_count);
        end
        sel = 0;
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_c_words();
        test_backpressure();
        test_random();
        test_mid_reset();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
